mem_line_ctrl: RTL and testbench

Main-memory controller on the downstream side of the 2-way cache's memory bus. It serves whole-line read and write-back commands on the shared `data2`/`ctrl2` bus. Each command gets a programmable access latency, then a response phase that the cache waits for. It also holds the backing line storage for the full 14-bit line address space.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_line_array.sv | 27 ++
 rtl/mem_line_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cache-to-memory line bus: ctrl2 encodings,
// controller state type and default line geometry.
package mem_bus_pkg;

   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_RESP  = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;

   localparam int unsigned BUS_DATA_BITS  = 16;
   localparam int unsigned BUS_LINE_WORDS = 8;
   localparam int unsigned BUS_LINE_BITS  = BUS_LINE_WORDS * BUS_DATA_BITS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_COLLECT,
      ST_WAIT,
      ST_RD_BURST,
      ST_WR_ACK,
      ST_TURN
   } state_t;

endpackage

// File: rtl/mem_line_array.sv
// Backing line storage: one full-line synchronous write port and one
// combinational full-line read port. Contents are not reset.
module mem_line_array
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 14,
   parameter int unsigned LINE_BITS = BUS_LINE_BITS
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [LINE_BITS-1:0] wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [LINE_BITS-1:0] rdata
);

   logic [LINE_BITS-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_line_ctrl.sv
// Main-memory line controller: whole-line reads and write-backs over the
// shared data2/ctrl2 bus with a programmable access latency.
module mem_line_ctrl
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR_BITS  = 14,
   parameter int unsigned DATA_BITS  = BUS_DATA_BITS,
   parameter int unsigned LINE_WORDS = BUS_LINE_WORDS,
   parameter int unsigned LATENCY    = 100
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_BITS-1:0] addr2,
   inout  wire  [DATA_BITS-1:0] data2,
   inout  wire  [1:0]           ctrl2,
   output logic                 busy,
   output logic                 proto_err
);

   localparam int unsigned LINE_BITS = LINE_WORDS * DATA_BITS;
   localparam int unsigned CNT_BITS  = $clog2(LATENCY + 1);
   localparam int unsigned IDX_BITS  = $clog2(LINE_WORDS);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LINE_WORDS - 1);
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q;
   logic [LINE_BITS-1:0] line_q;
   logic [LINE_BITS-1:0] rd_line;
   logic [LINE_BITS-1:0] wr_line;
   logic [CNT_BITS-1:0]  cnt_q;
   logic [IDX_BITS-1:0]  idx_q;
   logic                 is_wr_q;
   logic                 perr_q;
   logic                 mem_we;
   logic                 cmd_read;
   logic                 cmd_write;

   // Z/X on ctrl2 compares false, so a floating bus reads as NOP.
   assign cmd_read  = (ctrl2 == CMD_READ);
   assign cmd_write = (ctrl2 == CMD_WRITE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mem_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_read) begin
               state_d = ST_WAIT;
            end else if (cmd_write) begin
               state_d = ST_WR_COLLECT;
            end
         end
         ST_WR_COLLECT: begin
            if (idx_q == LAST_IDX) begin
               mem_we  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = is_wr_q ? ST_WR_ACK : ST_RD_BURST;
            end
         end
         ST_RD_BURST: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_TURN;
            end
         end
         ST_WR_ACK: state_d = ST_TURN;
         ST_TURN:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // A reset on the last collect edge drops the partial line.
      if (reset) begin
         mem_we = 1'b0;
      end
   end

   always_comb begin
      wr_line = line_q;
      wr_line[(LINE_WORDS-1)*DATA_BITS +: DATA_BITS] = data2;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         is_wr_q <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         perr_q <= (state_q != ST_IDLE) && (cmd_read || cmd_write);
         unique case (state_q)
            ST_IDLE: begin
               idx_q <= '0;
               if (cmd_read) begin
                  addr_q  <= addr2;
                  line_q  <= rd_line;
                  is_wr_q <= 1'b0;
                  cnt_q   <= CNT_LOAD;
               end else if (cmd_write) begin
                  addr_q                <= addr2;
                  line_q[DATA_BITS-1:0] <= data2;
                  idx_q                 <= IDX_BITS'(1);
                  is_wr_q               <= 1'b1;
               end
            end
            ST_WR_COLLECT: begin
               line_q[idx_q*DATA_BITS +: DATA_BITS] <= data2;
               if (idx_q == LAST_IDX) begin
                  idx_q <= '0;
                  cnt_q <= CNT_LOAD;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RD_BURST: begin
               if (idx_q == LAST_IDX) begin
                  idx_q <= '0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   mem_line_array #(
      .ADDR_BITS(ADDR_BITS),
      .LINE_BITS(LINE_BITS)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .waddr(addr_q),
      .wdata(wr_line),
      .raddr(addr2),
      .rdata(rd_line)
   );

   assign data2 = (state_q == ST_RD_BURST) ? line_q[idx_q*DATA_BITS +: DATA_BITS] : 'z;
   assign ctrl2 = (state_q == ST_RD_BURST || state_q == ST_WR_ACK) ? CMD_RESP : 2'bzz;

   assign busy      = (state_q != ST_IDLE);
   assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl: two instances (latency 4 and 1) driven
// with directed and random line commands against an associative-array memory model.
module tb_mem_line_ctrl;
   import mem_bus_pkg::*;

   localparam int unsigned AB   = 14;
   localparam int unsigned DB   = 16;
   localparam int unsigned LW   = 8;
   localparam int unsigned LB   = LW * DB;
   localparam int unsigned LAT0 = 4;
   localparam int unsigned LAT1 = 1;

   typedef struct {
      bit            is_read;
      logic [LB-1:0] line;
      int            start;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]    rst = 2'b11;
   logic [AB-1:0] addr [2];
   logic [1:0]    c_en = 2'b00;
   logic [1:0]    d_en = 2'b00;
   logic [1:0]    c_drv [2];
   logic [DB-1:0] d_drv [2];
   logic [1:0]    busy;
   logic [1:0]    perr;
   wire  [1:0]    ctrl_a, ctrl_b;
   wire  [DB-1:0] data_a, data_b;

   assign ctrl_a = c_en[0] ? c_drv[0] : 2'bzz;
   assign ctrl_b = c_en[1] ? c_drv[1] : 2'bzz;
   assign data_a = d_en[0] ? d_drv[0] : 'z;
   assign data_b = d_en[1] ? d_drv[1] : 'z;

   mem_line_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .LINE_WORDS(LW), .LATENCY(LAT0)) dut0 (
      .clk(clk), .reset(rst[0]), .addr2(addr[0]), .data2(data_a), .ctrl2(ctrl_a),
      .busy(busy[0]), .proto_err(perr[0]));

   mem_line_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .LINE_WORDS(LW), .LATENCY(LAT1)) dut1 (
      .clk(clk), .reset(rst[1]), .addr2(addr[1]), .data2(data_b), .ctrl2(ctrl_b),
      .busy(busy[1]), .proto_err(perr[1]));

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   exp_t          q0[$];
   exp_t          q1[$];
   logic [LB-1:0] model [int];
   bit            in_burst [2] = '{0, 0};
   bit            expect_end [2] = '{0, 0};
   bit            abort [2] = '{0, 0};
   bit            perr_allow [2] = '{0, 0};
   int            widx [2];
   exp_t          cur [2];
   logic [AB-1:0] pool [6] = '{14'h0000, 14'h3FFF, 14'h0123, 14'h2AAA, 14'h1555, 14'h0001};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int key(input int i, input logic [AB-1:0] a);
      return i * 65536 + int'(a);
   endfunction

   function automatic int lat(input int i);
      return (i == 0) ? int'(LAT0) : int'(LAT1);
   endfunction

   function automatic logic [LB-1:0] seq_line(input logic [DB-1:0] base);
      logic [LB-1:0] l;
      for (int w = 0; w < int'(LW); w++) l[w*DB +: DB] = base + DB'(w);
      return l;
   endfunction

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] l;
      for (int w = 0; w < int'(LW); w++) l[w*DB +: DB] = DB'($urandom);
      return l;
   endfunction

   task automatic push_exp(input int i, input exp_t e);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Monitor: pops the oldest expected response whenever a response appears.
   task automatic mon(input int i);
      logic [1:0]    c;
      logic [DB-1:0] d;
      c = (i == 0) ? ctrl_a : ctrl_b;
      d = (i == 0) ? data_a : data_b;
      check("perr_spurious", LB'(perr[i] & ~perr_allow[i]), '0);
      if (abort[i]) begin
         abort[i] = 0;
         in_burst[i] = 0;
         expect_end[i] = 0;
         check("rst_ctrl_released", LB'(c == CMD_RESP), '0);
         check("rst_busy", LB'(busy[i]), '0);
      end else if (expect_end[i]) begin
         expect_end[i] = 0;
         check("resp_end", LB'(c == CMD_RESP), '0);
      end else if (in_burst[i]) begin
         check("rd_ctrl", LB'(c), LB'(CMD_RESP));
         check("rd_word", LB'(d), LB'(cur[i].line[widx[i]*DB +: DB]));
         widx[i]++;
         if (widx[i] == int'(LW)) begin
            in_burst[i] = 0;
            expect_end[i] = 1;
         end
      end else if (c == CMD_RESP) begin
         if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: inst %0d response at cycle %0d, required none", i, cyc);
         end else begin
            cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
            check("resp_cycle", LB'(cyc), LB'(cur[i].start));
            if (cur[i].is_read) begin
               check("rd_word", LB'(d), LB'(cur[i].line[DB-1:0]));
               widx[i] = 1;
               in_burst[i] = 1;
            end else begin
               expect_end[i] = 1;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst == 2'b00 || total > 0) begin
         mon(0);
         mon(1);
      end
   end

   // All stimulus tasks start and end 2 ns after a posedge.
   task automatic do_read(input int i, input logic [AB-1:0] a, output int t);
      exp_t e;
      addr[i] = a;
      c_drv[i] = CMD_READ;
      c_en[i] = 1'b1;
      @(posedge clk);
      #2;
      c_en[i] = 1'b0;
      t = cyc;
      e.is_read = 1;
      e.line = model.exists(key(i, a)) ? model[key(i, a)] : 'x;
      e.start = t + lat(i);
      push_exp(i, e);
   endtask

   task automatic do_write(input int i, input logic [AB-1:0] a, input logic [LB-1:0] l);
      exp_t e;
      addr[i] = a;
      c_drv[i] = CMD_WRITE;
      c_en[i] = 1'b1;
      d_en[i] = 1'b1;
      d_drv[i] = l[DB-1:0];
      @(posedge clk);
      #2;
      c_drv[i] = CMD_NOP;
      for (int w = 1; w < int'(LW); w++) begin
         d_drv[i] = l[w*DB +: DB];
         @(posedge clk);
         #2;
      end
      c_en[i] = 1'b0;
      d_en[i] = 1'b0;
      model[key(i, a)] = l;
      e.is_read = 0;
      e.line = '0;
      e.start = cyc + lat(i);
      push_exp(i, e);
   endtask

   task automatic wait_idle(input int i, output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy[i] && n < 400);
      t = cyc;
      check("idle_timeout", LB'(busy[i]), '0);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, ti;
      logic [AB-1:0] a;
      logic [LB-1:0] old_line;

      addr[0] = '0; addr[1] = '0;
      c_drv[0] = CMD_NOP; c_drv[1] = CMD_NOP;
      d_drv[0] = '0; d_drv[1] = '0;
      repeat (3) @(posedge clk);
      #2;
      rst = 2'b00;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_busy", LB'(busy[i]), '0);
         check("reset_perr", LB'(perr[i]), '0);
         check("reset_ctrl", LB'((i == 0 ? ctrl_a : ctrl_b) == CMD_RESP), '0);
      end
      @(posedge clk);
      #2;

      // Line 0x0123 preloaded with 0x1000..0x1007, then read back with latency 4.
      do_write(0, 14'h0123, seq_line(16'h1000));
      wait_idle(0, ti);
      do_read(0, 14'h0123, t);
      wait_idle(0, ti);
      check("busy_fall", LB'(ti), LB'(t + int'(LAT0) + int'(LW) + 1));

      // Top line address write then read.
      do_write(0, 14'h3FFF, seq_line(16'h00A0));
      wait_idle(0, ti);
      do_read(0, 14'h3FFF, t);
      wait_idle(0, ti);

      // Second READ during WAIT: one proto_err pulse, command ignored.
      do_read(0, 14'h0123, t);
      @(posedge clk);
      #2;
      perr_allow[0] = 1;
      addr[0] = 14'h3FFF;
      c_drv[0] = CMD_READ;
      c_en[0] = 1'b1;
      @(posedge clk);
      #2;
      c_en[0] = 1'b0;
      @(negedge clk);
      check("perr_pulse", LB'(perr[0]), LB'(1));
      @(negedge clk);
      check("perr_one_cycle", LB'(perr[0]), '0);
      perr_allow[0] = 0;
      wait_idle(0, ti);

      // Reset after word 3 of a write: partial line is discarded.
      old_line = model[key(0, 14'h0123)];
      addr[0] = 14'h0123;
      c_drv[0] = CMD_WRITE;
      c_en[0] = 1'b1;
      d_en[0] = 1'b1;
      d_drv[0] = 16'hDEAD;
      @(posedge clk);
      #2;
      c_drv[0] = CMD_NOP;
      for (int w = 1; w < 4; w++) begin
         d_drv[0] = 16'hBEE0 + 16'(w);
         @(posedge clk);
         #2;
      end
      rst[0] = 1'b1;
      c_en[0] = 1'b0;
      d_en[0] = 1'b0;
      @(posedge clk);
      #2;
      rst[0] = 1'b0;
      @(negedge clk);
      check("wrrst_busy", LB'(busy[0]), '0);
      check("wrrst_ctrl", LB'(ctrl_a == CMD_RESP), '0);
      @(posedge clk);
      #2;
      do_read(0, 14'h0123, t);
      wait_idle(0, ti);
      check("wrrst_model_kept", model[key(0, 14'h0123)], old_line);

      // Reset during word 2 of a burst, then an immediate new read.
      do_read(0, 14'h3FFF, t);
      repeat (LAT0 + 2) @(posedge clk);
      #2;
      rst[0] = 1'b1;
      @(posedge clk);
      #2;
      abort[0] = 1;
      rst[0] = 1'b0;
      do_read(0, 14'h0123, t);
      wait_idle(0, ti);

      // Latency 1: write then read of the same line right after the ack.
      do_write(1, 14'h0ABC, seq_line(16'h5A00));
      wait_idle(1, ti);
      do_read(1, 14'h0ABC, t);
      wait_idle(1, ti);

      // Random traffic on both instances.
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 25; n++) begin
            a = pool[$urandom_range(0, 5)];
            if (!model.exists(key(i, a)) || $urandom_range(0, 1) == 1) begin
               do_write(i, a, rand_line());
            end else begin
               do_read(i, a, t);
            end
            wait_idle(i, ti);
         end
      end

      repeat (3) @(posedge clk);
      check("queue_drained", LB'(q0.size() + q1.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
